// File: rtl/pkt_tx_pkg.sv
// Shared types and constant tables for the packet transmit assembler:
// packet types, word-field selectors, FSM states, per-type word lists and lengths.
package pkt_tx_pkg;

    typedef enum logic [2:0] {
        PT_HEARTBEAT     = 3'd0,
        PT_SLOT_ANNOUNCE = 3'd1,
        PT_INVITATION    = 3'd2,
        PT_MEMBER_REQ    = 3'd3,
        PT_DATA          = 3'd4
    } pkt_type_e;

    typedef enum logic [2:0] {
        F_HDR, F_SRC, F_DEST, F_HOPS, F_Q, F_E, F_CCH, F_HCH
    } field_e;

    typedef enum logic [2:0] {
        ST_IDLE, ST_WAIT_SLOT, ST_WAIT_OK, ST_SEND, ST_DONE
    } state_e;

    localparam logic [15:0] DEFAULT_COST_NEAR = 16'h0005;
    localparam logic [15:0] DEFAULT_COST_FAR  = 16'h001b;

    localparam int NUM_TYPES = 5;
    localparam int MAX_WORDS = 8;

    // Unused tail entries are never reached: the length table bounds the index.
    localparam field_e WORD_TABLE [NUM_TYPES][MAX_WORDS] = '{
        '{F_HDR, F_SRC, F_HOPS, F_Q,    F_E, F_HDR, F_HDR, F_HDR},
        '{F_HDR, F_SRC, F_DEST, F_HOPS, F_HDR, F_HDR, F_HDR, F_HDR},
        '{F_HDR, F_SRC, F_HOPS, F_Q,    F_E, F_HCH, F_HDR, F_HDR},
        '{F_HDR, F_SRC, F_DEST, F_HOPS, F_Q, F_E,   F_CCH, F_HCH},
        '{F_HDR, F_SRC, F_DEST, F_HOPS, F_Q, F_E,   F_HDR, F_HDR}
    };

    localparam logic [3:0] PKT_LEN [NUM_TYPES] = '{4'd5, 4'd4, 4'd6, 4'd8, 4'd6};

    function automatic logic type_valid(input logic [2:0] t);
        return t <= PT_DATA;
    endfunction

    function automatic logic [3:0] pkt_len(input logic [2:0] t);
        if (!type_valid(t)) return 4'd0;
        return PKT_LEN[t];
    endfunction

    function automatic field_e field_sel(input logic [2:0] t, input logic [2:0] idx);
        if (!type_valid(t)) return F_HDR;
        return WORD_TABLE[t][idx];
    endfunction

endpackage

// File: rtl/pkt_slot_timer.sv
// TDMA slot wait counter: load with a slot index, pulses expire_o on the last
// cycle of a slot*SLOT_CYCLES wait (slot 0 or 6'h3F waits a single cycle).
module pkt_slot_timer #(
    parameter int SLOT_CYCLES = 32
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       load_i,
    input  logic [5:0] slot_i,
    output logic       expire_o
);

    logic [11:0] count_q, count_d;
    logic [11:0] wait_len;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        wait_len = 12'(slot_i) * 12'(SLOT_CYCLES);
        if (slot_i == 6'd0 || slot_i == 6'h3F || wait_len == 12'd0) begin
            wait_len = 12'd1;
        end

        count_d = count_q;
        if (load_i) begin
            count_d = wait_len;
        end else if (count_q != 12'd0) begin
            count_d = count_q - 12'd1;
        end
    end

    assign expire_o = (count_q == 12'd1);

    always_ff @(posedge clk or negedge nrst) begin
        // NOTE: sequential state uses <= so every register samples pre-edge values.
        if (!nrst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/pkt_tx_assembler.sv
// Latches reward-stage packet fields, waits for the TDMA slot and okToSend, then
// streams the packet over valid/ready. PKT_TX_CHECKSUM_EN appends an XOR checksum word.
module pkt_tx_assembler
    import pkt_tx_pkg::*;
#(
    parameter int          WORD_WIDTH  = 16,
    parameter int          SLOT_CYCLES = 32,
    parameter logic [15:0] COST_NEAR   = DEFAULT_COST_NEAR,
    parameter logic [15:0] COST_FAR    = DEFAULT_COST_FAR
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  reward_done,
    input  logic                  tx_setting,
    input  logic [2:0]            rPacketType,
    input  logic [WORD_WIDTH-1:0] rSourceID,
    input  logic [WORD_WIDTH-1:0] rDestinationID,
    input  logic [WORD_WIDTH-1:0] rSourceHops,
    input  logic [WORD_WIDTH-1:0] rQValue,
    input  logic [WORD_WIDTH-1:0] rEnergyLeft,
    input  logic [WORD_WIDTH-1:0] rChosenCH,
    input  logic [WORD_WIDTH-1:0] rHopsFromCH,
    input  logic [5:0]            rTimeslot,
    input  logic                  okToSend,
    input  logic                  tx_ready,
    output logic [WORD_WIDTH-1:0] tx_word,
    output logic                  tx_valid,
    output logic                  tx_last,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           txEnergyCost,
    output logic                  drop
);

`ifdef PKT_TX_CHECKSUM_EN
    localparam logic CSUM_EN = 1'b1;
`else
    localparam logic CSUM_EN = 1'b0;
`endif

    state_e                state_q;
    pkt_type_e             ptype_q;
    logic [WORD_WIDTH-1:0] src_q, dest_q, hops_q, q_q, e_q, cch_q, hch_q;
    logic [5:0]            ts_q;
    logic                  far_q;
    logic [3:0]            idx_q;
    logic [WORD_WIDTH-1:0] csum_q, csum_d;
    logic [WORD_WIDTH-1:0] tx_word_q;
    logic                  tx_valid_q, tx_last_q, busy_q, done_q, drop_q;
    logic [15:0]           cost_q;

    logic                  start_accept, slot_expire, fire;
    logic [3:0]            idx_next, pkt_words;
    logic [WORD_WIDTH-1:0] header, next_word;
    logic                  next_last;

    assign start_accept = (state_q == ST_IDLE) && reward_done && type_valid(rPacketType);
    assign fire         = tx_valid_q && tx_ready;
    assign idx_next     = idx_q + 4'd1;
    assign pkt_words    = pkt_len(ptype_q) + {3'b000, CSUM_EN};
    assign header       = {ptype_q, {(WORD_WIDTH-9){1'b0}}, ts_q};

    pkt_slot_timer #(
        .SLOT_CYCLES(SLOT_CYCLES)
    ) u_slot_timer (
        .clk     (clk),
        .nrst    (nrst),
        .load_i  (start_accept),
        .slot_i  (rTimeslot),
        .expire_o(slot_expire)
    );

    // Word that follows the one currently on the bus, plus its running checksum.
    always_comb begin
        csum_d    = csum_q ^ tx_word_q;
        next_word = '0;
        case (field_sel(ptype_q, idx_next[2:0]))
            F_HDR:  next_word = header;
            F_SRC:  next_word = src_q;
            F_DEST: next_word = dest_q;
            F_HOPS: next_word = hops_q;
            F_Q:    next_word = q_q;
            F_E:    next_word = e_q;
            F_CCH:  next_word = cch_q;
            F_HCH:  next_word = hch_q;
            default: next_word = '0;
        endcase
        if (CSUM_EN && idx_next == pkt_len(ptype_q)) begin
            next_word = csum_d;
        end
        next_last = (idx_next == pkt_words - 4'd1);
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= ST_IDLE;
            ptype_q    <= PT_HEARTBEAT;
            src_q      <= '0;
            dest_q     <= '0;
            hops_q     <= '0;
            q_q        <= '0;
            e_q        <= '0;
            cch_q      <= '0;
            hch_q      <= '0;
            ts_q       <= '0;
            far_q      <= 1'b0;
            idx_q      <= '0;
            csum_q     <= '0;
            tx_word_q  <= '0;
            tx_valid_q <= 1'b0;
            tx_last_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            drop_q     <= 1'b0;
            cost_q     <= '0;
        end else begin
            done_q <= 1'b0;
            drop_q <= 1'b0;
            cost_q <= '0;
            // A start anywhere but IDLE (including the done cycle) is refused.
            if (reward_done && state_q != ST_IDLE) begin
                drop_q <= 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (reward_done) begin
                        ptype_q <= pkt_type_e'(rPacketType);
                        src_q   <= rSourceID;
                        dest_q  <= rDestinationID;
                        hops_q  <= rSourceHops;
                        q_q     <= rQValue;
                        e_q     <= rEnergyLeft;
                        cch_q   <= rChosenCH;
                        hch_q   <= rHopsFromCH;
                        ts_q    <= rTimeslot;
                        far_q   <= tx_setting;
                        if (type_valid(rPacketType)) begin
                            state_q <= ST_WAIT_SLOT;
                            busy_q  <= 1'b1;
                        end else begin
                            drop_q <= 1'b1;
                        end
                    end
                end
                ST_WAIT_SLOT: begin
                    if (slot_expire) begin
                        state_q <= ST_WAIT_OK;
                    end
                end
                ST_WAIT_OK: begin
                    if (okToSend) begin
                        state_q    <= ST_SEND;
                        idx_q      <= '0;
                        csum_q     <= '0;
                        tx_word_q  <= header;
                        tx_valid_q <= 1'b1;
                        tx_last_q  <= 1'b0;
                    end
                end
                ST_SEND: begin
                    if (fire) begin
                        if (tx_last_q) begin
                            state_q    <= ST_DONE;
                            tx_word_q  <= '0;
                            tx_valid_q <= 1'b0;
                            tx_last_q  <= 1'b0;
                            busy_q     <= 1'b0;
                            done_q     <= 1'b1;
                            cost_q     <= far_q ? COST_FAR : COST_NEAR;
                        end else begin
                            idx_q     <= idx_next;
                            csum_q    <= csum_d;
                            tx_word_q <= next_word;
                            tx_last_q <= next_last;
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign tx_word      = tx_word_q;
    assign tx_valid     = tx_valid_q;
    assign tx_last      = tx_last_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign drop         = drop_q;
    assign txEnergyCost = cost_q;

endmodule

// File: tb/tb_pkt_tx_assembler.sv
// Self-checking bench for pkt_tx_assembler: table of directed packets, hand-written
// reset/restart sequences and randomized packets against a list-based packet model.
module tb_pkt_tx_assembler;

`ifdef PKT_TX_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    typedef struct {
        logic [2:0]  ptype;
        logic [15:0] src, dest, hops, q, e, cch, hch;
        logic [5:0]  ts;
        logic        far;
    } pkt_t;

    typedef struct {
        pkt_t        p;
        int          ok_at;
        int          rmode;
        int          inject_at;
        bit          drop_on_done;
        logic        exp_drop;
        logic [15:0] exp_hdr;
        int          exp_len;
        logic [15:0] exp_cost;
    } vec_t;

    logic        clk = 1'b0;
    logic        nrst, reward_done, tx_setting, okToSend, tx_ready;
    logic [2:0]  rPacketType;
    logic [15:0] rSourceID, rDestinationID, rSourceHops, rQValue;
    logic [15:0] rEnergyLeft, rChosenCH, rHopsFromCH;
    logic [5:0]  rTimeslot;
    logic [15:0] tx_word, txEnergyCost;
    logic        tx_valid, tx_last, busy, done, drop;

    int total = 0;
    int bad   = 0;
    logic [15:0] exp_words[$];

    pkt_tx_assembler dut (
        .clk           (clk),
        .nrst          (nrst),
        .reward_done   (reward_done),
        .tx_setting    (tx_setting),
        .rPacketType   (rPacketType),
        .rSourceID     (rSourceID),
        .rDestinationID(rDestinationID),
        .rSourceHops   (rSourceHops),
        .rQValue       (rQValue),
        .rEnergyLeft   (rEnergyLeft),
        .rChosenCH     (rChosenCH),
        .rHopsFromCH   (rHopsFromCH),
        .rTimeslot     (rTimeslot),
        .okToSend      (okToSend),
        .tx_ready      (tx_ready),
        .tx_word       (tx_word),
        .tx_valid      (tx_valid),
        .tx_last       (tx_last),
        .busy          (busy),
        .done          (done),
        .txEnergyCost  (txEnergyCost),
        .drop          (drop)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic pkt_t mk_pkt(input logic [2:0] t, input logic [15:0] src, dest, hops, q, e,
                                    cch, hch, input logic [5:0] ts, input logic far);
        pkt_t p;
        p.ptype = t; p.src = src; p.dest = dest; p.hops = hops; p.q = q; p.e = e;
        p.cch = cch; p.hch = hch; p.ts = ts; p.far = far;
        return p;
    endfunction

    function automatic pkt_t rand_pkt();
        return mk_pkt(3'($urandom_range(0, 4)), 16'($urandom), 16'($urandom), 16'($urandom),
                      16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                      6'($urandom), 1'($urandom_range(0, 1)));
    endfunction

    function automatic vec_t mk_vec(input pkt_t p, input int ok_at, rmode, inject_at,
                                    input bit dod, input logic edrop, input logic [15:0] hdr,
                                    input int len, input logic [15:0] cost);
        vec_t v;
        v.p = p; v.ok_at = ok_at; v.rmode = rmode; v.inject_at = inject_at;
        v.drop_on_done = dod; v.exp_drop = edrop; v.exp_hdr = hdr; v.exp_len = len;
        v.exp_cost = cost;
        return v;
    endfunction

    // Packet as a plain list of words built from the per-type field order.
    function automatic void model_packet(input pkt_t p);
        logic [15:0] hdr;
        logic [15:0] x;
        hdr = {p.ptype, 7'b0, p.ts};
        exp_words.delete();
        case (p.ptype)
            3'd0: exp_words = '{hdr, p.src, p.hops, p.q, p.e};
            3'd1: exp_words = '{hdr, p.src, p.dest, p.hops};
            3'd2: exp_words = '{hdr, p.src, p.hops, p.q, p.e, p.hch};
            3'd3: exp_words = '{hdr, p.src, p.dest, p.hops, p.q, p.e, p.cch, p.hch};
            default: exp_words = '{hdr, p.src, p.dest, p.hops, p.q, p.e};
        endcase
        if (CS == 1) begin
            x = '0;
            foreach (exp_words[i]) x = x ^ exp_words[i];
            exp_words.push_back(x);
        end
    endfunction

    task automatic drive_pkt(input pkt_t p);
        rPacketType = p.ptype; rSourceID = p.src; rDestinationID = p.dest;
        rSourceHops = p.hops; rQValue = p.q; rEnergyLeft = p.e; rChosenCH = p.cch;
        rHopsFromCH = p.hch; rTimeslot = p.ts; tx_setting = p.far;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_tx_word"}, 32'(tx_word), 0);
        check({tag, "_tx_valid"}, 32'(tx_valid), 0);
        check({tag, "_tx_last"}, 32'(tx_last), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_drop"}, 32'(drop), 0);
        check({tag, "_cost"}, 32'(txEnergyCost), 0);
    endtask

    // One full transaction: start strobe, slot/okToSend wait, transfers, done pulse.
    task automatic run_packet(input pkt_t p, input int ok_at, input int rmode, input int inject_at,
                              input bit drop_on_done, output logic [15:0] first_word,
                              output int n_xfer, output logic [15:0] cost_seen);
        int keff, s, first_valid, want_valid, n, k, budget, pi;
        bit inj_done, inj_pending, rdy;
        logic [15:0] want_cost;
        first_word = '0; n_xfer = 0; cost_seen = '0;
        model_packet(p);
        n = exp_words.size();
        keff = (p.ts == 6'd0 || p.ts == 6'h3F) ? 1 : int'(p.ts) * 32;
        want_valid = ((ok_at > keff + 1) ? ok_at : keff + 1) + 1;
        want_cost = p.far ? 16'h001B : 16'h0005;

        tx_ready = 1'b0;
        okToSend = (ok_at == 0);
        drive_pkt(p);
        reward_done = 1'b1;
        step();
        reward_done = 1'b0;
        check("busy_rise", 32'(busy), 1);

        s = 1;
        first_valid = -1;
        while (s <= want_valid + 4) begin
            if (tx_valid) begin
                first_valid = s;
                break;
            end
            if (s == ok_at) okToSend = 1'b1;
            step();
            s++;
        end
        check("first_valid_cycle", first_valid, want_valid);
        if (first_valid < 0) return;

        first_word = tx_word;
        k = 0; pi = 0; budget = 0; inj_done = 0; inj_pending = 0;
        while (k < n && budget < 400) begin
            if (inj_pending) begin
                reward_done = 1'b0;
                inj_pending = 0;
                check("busy_start_drop", 32'(drop), 1);
            end
            if (!tx_valid) begin
                check("valid_held", 32'(tx_valid), 1);
                break;
            end
            check($sformatf("word%0d", k), 32'(tx_word), 32'(exp_words[k]));
            check($sformatf("last%0d", k), 32'(tx_last), 32'(k == n - 1));
            if (k == inject_at && !inj_done) begin
                drive_pkt(rand_pkt());
                reward_done = 1'b1;
                inj_done = 1;
                inj_pending = 1;
            end
            case (rmode)
                0:       rdy = 1'b1;
                1:       rdy = (pi % 4 == 0) || (pi % 4 == 3);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            if (rmode == 2) okToSend = 1'($urandom_range(0, 1));
            pi++;
            tx_ready = rdy;
            if (rdy) k++;
            step();
            budget++;
        end
        tx_ready = 1'b0;
        if (inj_pending) begin
            reward_done = 1'b0;
            check("busy_start_drop", 32'(drop), 1);
        end
        n_xfer = k;
        check("xfer_count", k, n);
        check("done_pulse", 32'(done), 1);
        check("busy_fall", 32'(busy), 0);
        check("valid_after_last", 32'(tx_valid), 0);
        check("cost", 32'(txEnergyCost), 32'(want_cost));
        cost_seen = txEnergyCost;

        if (drop_on_done) begin
            drive_pkt(rand_pkt());
            rPacketType = 3'd0;
            reward_done = 1'b1;
            step();
            reward_done = 1'b0;
            check("done_cycle_drop", 32'(drop), 1);
            check("done_cycle_no_busy", 32'(busy), 0);
            step();
            check("done_cycle_not_started", 32'(busy), 0);
        end else begin
            step();
            check("done_one_cycle", 32'(done), 0);
            check("cost_one_cycle", 32'(txEnergyCost), 0);
        end
    endtask

    initial begin
        vec_t        vecs[8];
        pkt_t        p;
        logic [15:0] fw, cost;
        int          nx, keff, seen;

        vecs[0] = mk_vec(mk_pkt(3'd0, 16'h000C, 16'h0000, 16'h0003, 16'h3555, 16'h7FFC,
                                16'h0000, 16'h0000, 6'd0, 1'b0),
                         0, 0, -1, 0, 1'b0, 16'h0000, 5 + CS, 16'h0005);
        vecs[1] = mk_vec(mk_pkt(3'd3, 16'h0042, 16'd23, 16'h0004, 16'h1234, 16'h0800,
                                16'd23, 16'h0001, 6'd2, 1'b1),
                         0, 0, 2, 0, 1'b0, 16'h6002, 8 + CS, 16'h001B);
        vecs[2] = mk_vec(mk_pkt(3'd2, 16'h0007, 16'h0000, 16'h0002, 16'h2AAA, 16'h5000,
                                16'h0000, 16'h0003, 6'd5, 1'b0),
                         200, 1, -1, 0, 1'b0, 16'h4005, 6 + CS, 16'h0005);
        vecs[3] = mk_vec(mk_pkt(3'd1, 16'h0011, 16'h0022, 16'h0001, 16'hAAAA, 16'h5555,
                                16'h1111, 16'h2222, 6'h3F, 1'b1),
                         0, 2, -1, 0, 1'b0, 16'h203F, 4 + CS, 16'h001B);
        vecs[4] = mk_vec(mk_pkt(3'd4, 16'hBEEF, 16'hCAFE, 16'h0007, 16'h0F0F, 16'hF0F0,
                                16'h0000, 16'h0000, 6'd1, 1'b0),
                         40, 1, -1, 1, 1'b0, 16'h8001, 6 + CS, 16'h0005);
        vecs[5] = mk_vec(mk_pkt(3'd7, 16'h1, 16'h2, 16'h3, 16'h4, 16'h5, 16'h6, 16'h7, 6'd0, 1'b0),
                         0, 0, -1, 0, 1'b1, 16'h0000, 0, 16'h0000);
        vecs[6] = mk_vec(mk_pkt(3'd5, 16'h1, 16'h2, 16'h3, 16'h4, 16'h5, 16'h6, 16'h7, 6'd1, 1'b1),
                         0, 0, -1, 0, 1'b1, 16'h0000, 0, 16'h0000);
        vecs[7] = mk_vec(mk_pkt(3'd6, 16'h1, 16'h2, 16'h3, 16'h4, 16'h5, 16'h6, 16'h7, 6'd2, 1'b0),
                         0, 0, -1, 0, 1'b1, 16'h0000, 0, 16'h0000);

        nrst = 1'b0;
        reward_done = 1'b0;
        okToSend = 1'b0;
        tx_ready = 1'b0;
        drive_pkt(mk_pkt(3'd0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 6'd0, 1'b0));
        step();
        step();
        check_all_zero("reset");
        nrst = 1'b1;
        step();

        // Directed table.
        for (int i = 0; i < 8; i++) begin
            if (vecs[i].exp_drop) begin
                drive_pkt(vecs[i].p);
                reward_done = 1'b1;
                step();
                reward_done = 1'b0;
                check($sformatf("v%0d_drop", i), 32'(drop), 1);
                check($sformatf("v%0d_no_busy", i), 32'(busy), 0);
                step();
                check($sformatf("v%0d_drop_once", i), 32'(drop), 0);
                check($sformatf("v%0d_stay_idle", i), 32'(busy | tx_valid), 0);
            end else begin
                run_packet(vecs[i].p, vecs[i].ok_at, vecs[i].rmode, vecs[i].inject_at,
                           vecs[i].drop_on_done, fw, nx, cost);
                check($sformatf("v%0d_hdr", i), 32'(fw), 32'(vecs[i].exp_hdr));
                check($sformatf("v%0d_len", i), nx, vecs[i].exp_len);
                check($sformatf("v%0d_cost", i), 32'(cost), 32'(vecs[i].exp_cost));
            end
        end

        // Reset in the middle of a membership request, then a clean resend.
        p = mk_pkt(3'd3, 16'h0101, 16'h0202, 16'h0303, 16'h0404, 16'h0505, 16'h0606, 16'h0707,
                   6'd0, 1'b1);
        okToSend = 1'b1;
        tx_ready = 1'b0;
        drive_pkt(p);
        reward_done = 1'b1;
        step();
        reward_done = 1'b0;
        seen = 0;
        while (!tx_valid && seen < 20) begin
            step();
            seen++;
        end
        check("rst_seq_valid", 32'(tx_valid), 1);
        tx_ready = 1'b1;
        repeat (3) step();
        check("rst_seq_word3", 32'(tx_word), 32'(16'h0303));
        #2 nrst = 1'b0;
        #1;
        check_all_zero("midrst");
        step();
        step();
        nrst = 1'b1;
        seen = 0;
        repeat (6) begin
            step();
            if (done || tx_valid || busy) seen = 1;
        end
        check("rst_no_done", seen, 0);
        run_packet(p, 0, 0, -1, 0, fw, nx, cost);

        // Randomized packets.
        for (int i = 0; i < 25; i++) begin
            p = rand_pkt();
            case ($urandom_range(0, 4))
                0: p.ts = 6'd0;
                1: p.ts = 6'd1;
                2: p.ts = 6'd2;
                3: p.ts = 6'd3;
                default: p.ts = 6'h3F;
            endcase
            keff = (p.ts == 6'd0 || p.ts == 6'h3F) ? 1 : int'(p.ts) * 32;
            run_packet(p, int'($urandom_range(0, keff + 6)), 2,
                       ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1,
                       1'($urandom_range(0, 1)), fw, nx, cost);
            if (p.far == 1'b0) begin
                step();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
